// File: rtl/param_intf_pkg.sv
// param_intf_pkg: read-select encoding and default function-query constant.
package param_intf_pkg;
  typedef enum logic [1:0] {
    SEL_VAL    = 2'd0,
    SEL_FUNC   = 2'd1,
    SEL_PARAM  = 2'd2,
    SEL_STATUS = 2'd3
  } sel_e;
  localparam int unsigned FUNC_VALUE_DEFAULT = 5;
endpackage

// File: rtl/param_intf_rsp_reg.sv
// param_intf_rsp_reg: one-entry response holding register with valid/ready handshake.
module param_intf_rsp_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  input  logic        in_err_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic        out_err_o,
  input  logic        out_ready_i
);
  logic        valid_q, valid_d, err_q, err_d, load;
  logic [31:0] data_q, data_d;
  // Accept a new entry whenever the slot is empty or being drained this cycle.
  assign in_ready_o = !valid_q || out_ready_i;
  assign load = in_valid_i && in_ready_o;
  always_comb begin
    valid_d = load ? 1'b1 : valid_q && !out_ready_i;
    data_d  = load ? in_data_i : data_q;
    err_d   = load ? in_err_i : err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_err_o   = err_q;
endmodule

// File: rtl/param_intf.sv
// param_intf: one-bit val register plus a select-based read port with registered response.
module param_intf
  import param_intf_pkg::*;
#(
  parameter int unsigned PARAM      = 0,
  parameter int unsigned FUNC_VALUE = FUNC_VALUE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        val_we,
  input  logic        val_d,
  output logic        val,
  input  logic        req_valid,
  input  logic [1:0]  req_sel,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready
);
  logic        val_q, written_q;
  logic [31:0] rdata;
  logic        rerr;
  // Read data is taken from the pre-write register state of the accepting edge.
  always_comb begin
    rdata = req_sel == SEL_VAL   ? {31'b0, val_q} :
            req_sel == SEL_FUNC  ? 32'(FUNC_VALUE) :
            req_sel == SEL_PARAM ? 32'(PARAM) :
                                   {30'b0, written_q, val_q};
    rerr  = req_sel == SEL_STATUS && !written_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q     <= 1'b0;
      written_q <= 1'b0;
    end else if (val_we) begin
      val_q     <= val_d;
      written_q <= 1'b1;
    end
  end
  assign val = val_q;
  param_intf_rsp_reg u_rsp (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (req_valid),
    .in_data_i   (rdata),
    .in_err_i    (rerr),
    .in_ready_o  (req_ready),
    .out_valid_o (rsp_valid),
    .out_data_o  (rsp_data),
    .out_err_o   (rsp_err),
    .out_ready_i (rsp_ready)
  );
endmodule

// File: tb/tb_param_intf.sv
// tb_param_intf: randomized and directed checks of two param_intf instances against a queue model.
module tb_param_intf;
  logic clk = 1'b0;
  logic rst_n, val_we, val_d, req_valid, rsp_ready;
  logic [1:0] req_sel;
  logic val0, req_ready0, rsp_valid0, rsp_err0;
  logic val1, req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_data0, rsp_data1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  param_intf dut0 (
    .clk(clk), .rst_n(rst_n), .val_we(val_we), .val_d(val_d), .val(val0),
    .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_err(rsp_err0), .rsp_ready(rsp_ready)
  );
  param_intf #(.PARAM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .val_we(val_we), .val_d(val_d), .val(val1),
    .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_err(rsp_err1), .rsp_ready(rsp_ready)
  );
  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        e;
  } rsp_t;
  rsp_t exp_q[$];
  logic m_val = 1'b0, m_wr = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    rsp_t r;
    logic acc;
    #1;
    check("req_ready0", {31'b0, req_ready0}, {31'b0, exp_q.size() == 0 || rsp_ready});
    check("req_ready1", {31'b0, req_ready1}, {31'b0, exp_q.size() == 0 || rsp_ready});
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_val = 1'b0;
      m_wr  = 1'b0;
    end else begin
      acc = req_valid && (exp_q.size() == 0 || rsp_ready);
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (acc) begin
        case (req_sel)
          2'd0: begin r.d0 = {31'b0, m_val}; r.d1 = r.d0; end
          2'd1: begin r.d0 = 5; r.d1 = 5; end
          2'd2: begin r.d0 = 0; r.d1 = 1; end
          default: begin r.d0 = {30'b0, m_wr, m_val}; r.d1 = r.d0; end
        endcase
        r.e = req_sel == 2'd3 && !m_wr;
        exp_q.push_back(r);
      end
      if (val_we) begin
        m_val = val_d;
        m_wr  = 1'b1;
      end
    end
    @(negedge clk);
    check("val0", {31'b0, val0}, {31'b0, m_val});
    check("val1", {31'b0, val1}, {31'b0, m_val});
    check("rsp_valid0", {31'b0, rsp_valid0}, {31'b0, exp_q.size() != 0});
    check("rsp_valid1", {31'b0, rsp_valid1}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("rsp_data0", rsp_data0, exp_q[0].d0);
      check("rsp_data1", rsp_data1, exp_q[0].d1);
      check("rsp_err0", {31'b0, rsp_err0}, {31'b0, exp_q[0].e});
      check("rsp_err1", {31'b0, rsp_err1}, {31'b0, exp_q[0].e});
    end
  endtask
  task automatic drv(input logic r, input logic we, input logic d, input logic rv,
                     input logic [1:0] s, input logic rr);
    rst_n = r; val_we = we; val_d = d; req_valid = rv; req_sel = s; rsp_ready = rr;
    cyc();
  endtask
  initial begin
    rst_n = 1'b0; val_we = 1'b0; val_d = 1'b0; req_valid = 1'b0; req_sel = 2'd0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 1);
    check("rst_data0", rsp_data0, 32'd0);
    check("rst_err0", {31'b0, rsp_err0}, 32'd0);
    check("rst_data1", rsp_data1, 32'd0);
    drv(1, 0, 0, 1, 1, 1);
    drv(1, 0, 0, 1, 2, 1);
    drv(1, 0, 0, 1, 3, 1);
    drv(1, 1, 0, 0, 0, 1);
    drv(1, 0, 0, 1, 0, 1);
    drv(1, 1, 1, 0, 0, 1);
    drv(1, 0, 0, 1, 0, 1);
    drv(1, 0, 0, 1, 3, 1);
    drv(1, 1, 0, 1, 3, 1);
    drv(1, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 1, 1, 0);
    repeat (3) drv(1, 0, 0, 1, 2, 0);
    repeat (4) drv(1, 0, 0, 1, 3, 1);
    drv(1, 0, 0, 0, 0, 1);
    drv(1, 1, 1, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0);
    check("rst_mid_valid", {31'b0, rsp_valid0}, 32'd0);
    check("rst_mid_val", {31'b0, val0}, 32'd0);
    drv(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      drv($urandom_range(49) != 0, $urandom_range(3) == 0, 1'($urandom), 1'($urandom),
          2'($urandom), $urandom_range(3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_intf.md
PARAM_INTF -- requirements
Module: param_intf

Interface
REQ-001 Parameter PARAM, default 0, 32-bit integer instance tag; readable back, no effect on datapath.
REQ-002 Parameter FUNC_VALUE, default 5, 32-bit constant returned by the function query.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 val_we  input  1  write enable for the val register.
REQ-006 val_d  input  1  data written to val when val_we=1.
REQ-007 val  output  1  current value of the shared val register.
REQ-008 req_valid  input  1  read request strobe.
REQ-009 req_sel  input  2  read select: 0=val, 1=func, 2=PARAM, 3=status.
REQ-010 req_ready  output  1  request accepted this cycle.
REQ-011 rsp_valid  output  1  read response valid.
REQ-012 rsp_data  output  32  read response data.
REQ-013 rsp_err  output  1  response flagged as error (select 3 when no write has occurred since reset).
REQ-014 rsp_ready  input  1  consumer accepts response.

Function
REQ-015 val SHALL load val_d on a rising edge with val_we=1 and hold otherwise; val is visible on its output the cycle after the write.
REQ-016 A request SHALL be accepted when req_valid=1 and req_ready=1; req_ready SHALL equal (!rsp_valid || rsp_ready).
REQ-017 Response SHALL appear exactly one cycle after acceptance: rsp_valid=1 with data per select.
REQ-018 Select 0 SHALL return val zero-extended to 32 bits, sampled at acceptance edge (pre-write value if val_we is active the same cycle).
REQ-019 Select 1 SHALL return FUNC_VALUE (5 by default), independent of all other state.
REQ-020 Select 2 SHALL return PARAM as 32-bit value.
REQ-021 Select 3 SHALL return status {30'b0, written_flag, val}; written_flag sets on first val_we after reset; rsp_err=1 iff written_flag=0.
REQ-022 rsp_err SHALL be 0 for selects 0-2.
REQ-023 rsp_valid/rsp_data/rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0 (backpressure).
REQ-024 Accept and retire in same cycle SHALL sustain one response per cycle.
REQ-025 Simultaneous val_we and select-3 request: status reflects pre-write state; the write still takes effect.

Reset
REQ-026 With rst_n=0 at a rising edge: val=0, written_flag=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-027 req_ready SHALL be 1 in the cycle after reset release.
REQ-028 Reset asserted mid-transaction SHALL drop the pending response without presenting it.

Structure
REQ-029 Shared package param_intf_pkg SHALL hold the select encoding (SEL_VAL, SEL_FUNC, SEL_PARAM, SEL_STATUS) and FUNC_VALUE default constant.
REQ-030 One sub-module param_intf_rsp_reg (one-entry response holding register with valid/ready) is natural; remaining logic stays in top.

Verification
REQ-031 Reset, then req_sel=1 accepted -> next cycle rsp_valid=1, rsp_data=5, rsp_err=0.
REQ-032 Instance PARAM=1: req_sel=2 -> rsp_data=1; default instance -> rsp_data=0.
REQ-033 val_we=1,val_d=0 then req_sel=0 -> rsp_data=0; val_d=1 write then read -> rsp_data=1.
REQ-034 Select 3 after reset, no writes -> rsp_data=0, rsp_err=1; after one write of 1 -> rsp_data=3, rsp_err=0.
REQ-035 Hold rsp_ready=0 three cycles with rsp pending -> req_ready=0, rsp_data stable; release -> back-to-back responses at one per cycle.
REQ-036 Assert rst_n=0 while response pending -> rsp_valid=0 next cycle, val=0.
